chip_clk_gen: RTL and testbench

Parametrised multi-channel clock/strobe generator that drives the sensor-chip clock pins from the 100 MHz CLK domain, replacing the fixed single 5 MHz chip clock. Each of NCH channels has its own programmable divide ratio and runs either free-running or in counted-burst mode, with a start/stop/busy/done handshake to the command/readout control logic. Outputs are registered and feed the output-pin DDR primitives.

---
 rtl/chip_clk_pkg.sv | 20 ++
 rtl/chip_clk_chan.sv | 146 ++++++++++++++
 rtl/chip_clk_gen.sv | 84 ++++++++
 tb/tb_chip_clk_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/chip_clk_pkg.sv
// Shared types and defaults for the multi-channel sensor-chip clock generator.
// Optional phase-delay feature is enabled by defining CLK_PHASE_EN.
package chip_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } chan_state_t;

    localparam logic MODE_FREE  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    localparam int DEF_NCH     = 2;
    localparam int DEF_DIV_W   = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_DIV_RST = 9;

endpackage

// File: rtl/chip_clk_chan.sv
// One clock/strobe channel: IDLE/PHASE/HIGH/LOW FSM with half-period, burst and stop handling.
// Phase-delay state and port exist only when CLK_PHASE_EN is defined.
module chip_clk_chan
    import chip_clk_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_mode,
    input  logic [CNT_W-1:0] i_count,
`ifdef CLK_PHASE_EN
    input  logic [DIV_W-1:0] i_phase,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic             o_clk,
    output logic             o_rise
);

    chan_state_t      r_state;
    logic [DIV_W-1:0] r_hcnt;
    logic [DIV_W-1:0] r_div_w;
    logic             r_mode_w;
    logic [CNT_W-1:0] r_bcnt;
    logic             r_stop;
    logic             r_busy;
    logic             r_done;
    logic             r_clk;
    logic             r_rise;
`ifdef CLK_PHASE_EN
    logic [DIV_W-1:0] r_phcnt;
`endif

    logic w_stop_any;
    logic w_burst_last;

    assign w_stop_any   = r_stop | i_stop;
    assign w_burst_last = (r_mode_w == MODE_BURST) && (r_bcnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_clk   <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_rise <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_stop <= 1'b0;
                    // A simultaneous stop cancels the start outright.
                    if (i_start && !i_stop) begin
                        r_div_w  <= i_div;
                        r_mode_w <= i_mode;
                        r_bcnt   <= i_count - CNT_W'(1);
                        if (i_mode == MODE_BURST && i_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy <= 1'b1;
`ifdef CLK_PHASE_EN
                            if (i_phase != '0) begin
                                r_state <= ST_PHASE;
                                r_phcnt <= i_phase - DIV_W'(1);
                            end else begin
                                r_state <= ST_HIGH;
                                r_clk   <= 1'b1;
                                r_rise  <= 1'b1;
                                r_hcnt  <= i_div;
                            end
`else
                            r_state <= ST_HIGH;
                            r_clk   <= 1'b1;
                            r_rise  <= 1'b1;
                            r_hcnt  <= i_div;
`endif
                        end
                    end
                end
`ifdef CLK_PHASE_EN
                ST_PHASE: begin
                    if (i_stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_phcnt == '0) begin
                        r_state <= ST_HIGH;
                        r_clk   <= 1'b1;
                        r_rise  <= 1'b1;
                        r_hcnt  <= r_div_w;
                    end else begin
                        r_phcnt <= r_phcnt - DIV_W'(1);
                    end
                end
`endif
                ST_HIGH: begin
                    if (i_stop) r_stop <= 1'b1;
                    if (r_hcnt == '0) begin
                        r_state <= ST_LOW;
                        r_clk   <= 1'b0;
                        r_hcnt  <= r_div_w;
                    end else begin
                        r_hcnt <= r_hcnt - DIV_W'(1);
                    end
                end
                ST_LOW: begin
                    if (r_hcnt == '0) begin
                        // End of a full period: the only point where the channel may leave.
                        if (w_stop_any || w_burst_last) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= ~w_stop_any;
                            r_stop  <= 1'b0;
                        end else begin
                            r_state <= ST_HIGH;
                            r_clk   <= 1'b1;
                            r_rise  <= 1'b1;
                            r_hcnt  <= r_div_w;
                            if (r_mode_w == MODE_BURST) r_bcnt <= r_bcnt - CNT_W'(1);
                        end
                    end else begin
                        r_hcnt <= r_hcnt - DIV_W'(1);
                        if (i_stop) r_stop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_clk   <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_clk  = r_clk;
    assign o_rise = r_rise;

endmodule

// File: rtl/chip_clk_gen.sv
// Multi-channel sensor-chip clock/strobe generator: config register file plus NCH channels.
// Define CLK_PHASE_EN to add a per-channel programmable start delay (cfg_phase).
module chip_clk_gen
    import chip_clk_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DIV_RST = DEF_DIV_RST
)(
    input  logic             CLK,
    input  logic             Reset,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   stop,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   done,
    output logic [NCH-1:0]   clk_o,
    output logic [NCH-1:0]   rise_o
);

    logic [DIV_W-1:0] r_div   [NCH];
    logic [NCH-1:0]   r_mode;
    logic [CNT_W-1:0] r_count [NCH];
`ifdef CLK_PHASE_EN
    logic [DIV_W-1:0] r_phase [NCH];
`else
    logic             w_unused_phase;
    assign w_unused_phase = ^cfg_phase;
`endif

    // Addresses at or above NCH match no channel and are dropped.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_mode <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_div[i]   <= DIV_W'(DIV_RST);
                r_count[i] <= '0;
`ifdef CLK_PHASE_EN
                r_phase[i] <= '0;
`endif
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_ch == 3'(i)) begin
                    r_div[i]   <= cfg_div;
                    r_mode[i]  <= cfg_mode;
                    r_count[i] <= cfg_count;
`ifdef CLK_PHASE_EN
                    r_phase[i] <= cfg_phase;
`endif
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        chip_clk_chan #(
            .DIV_W (DIV_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .i_clk   (CLK),
            .i_rst   (Reset),
            .i_start (start[g]),
            .i_stop  (stop[g]),
            .i_div   (r_div[g]),
            .i_mode  (r_mode[g]),
            .i_count (r_count[g]),
`ifdef CLK_PHASE_EN
            .i_phase (r_phase[g]),
`endif
            .o_busy  (busy[g]),
            .o_done  (done[g]),
            .o_clk   (clk_o[g]),
            .o_rise  (rise_o[g])
        );
    end

endmodule

// File: tb/tb_chip_clk_gen.sv
// Directed bench for chip_clk_gen: burst, free-run/stop, config timing, reset and phase cases.
// Expected timing is derived for both builds (with and without CLK_PHASE_EN).
module tb_chip_clk_gen;

    localparam int NCH = 2;
`ifdef CLK_PHASE_EN
    localparam int PH = 7;
`else
    localparam int PH = 0;
`endif

    logic           CLK = 1'b0;
    logic           Reset;
    logic           cfg_we;
    logic [2:0]     cfg_ch;
    logic [7:0]     cfg_div;
    logic           cfg_mode;
    logic [15:0]    cfg_count;
    logic [7:0]     cfg_phase;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
    logic [NCH-1:0] clk_o;
    logic [NCH-1:0] rise_o;

    int total = 0;
    int bad   = 0;
    int rises;
    logic seen;

    chip_clk_gen #(.NCH(NCH), .DIV_W(8), .CNT_W(16), .DIV_RST(9)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .cfg_count (cfg_count),
        .cfg_phase (cfg_phase),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .clk_o     (clk_o),
        .rise_o    (rise_o)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [7:0] dv, input logic md,
                       input logic [15:0] cn, input logic [7:0] ph);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_mode = md; cfg_count = cn; cfg_phase = ph;
        tick();
        cfg_we = 1'b0;
    endtask

    // After this returns the bench sits in cycle start+1.
    task automatic pulse_start(input logic [NCH-1:0] m);
        start = m;
        tick();
        start = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        cfg_count = '0; cfg_phase = '0; start = '0; stop = '0;
        tick(); tick();
        check("rst_busy", 8'(busy), 8'h0);
        check("rst_clk",  8'(clk_o), 8'h0);
        check("rst_rise", 8'(rise_o), 8'h0);
        check("rst_done", 8'(done), 8'h0);
        Reset = 1'b0;
        tick();

        // Burst of 3 with H=10 on ch0; ch1 must stay silent.
        cfg(3'd0, 8'd9, 1'b1, 16'd3, 8'd0);
        pulse_start(2'b01);
        rises = 0; seen = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            check("b3_clk",  8'(clk_o[0]), 8'(((k - 1) / 10) % 2 == 0));
            check("b3_rise", 8'(rise_o[0]), 8'((k - 1) % 20 == 0));
            check("b3_busy", 8'(busy[0]), 8'h1);
            if (rise_o[0]) rises++;
            seen = seen | clk_o[1] | busy[1] | done[0];
            tick();
        end
        check("b3_done",   8'(done[0]), 8'h1);
        check("b3_idle",   8'(busy[0]), 8'h0);
        check("b3_clkend", 8'(clk_o[0]), 8'h0);
        check("b3_rises",  8'(rises), 8'd3);
        check("b3_quiet",  8'(seen), 8'h0);
        tick();
        check("b3_donepulse", 8'(done[0]), 8'h0);

        // Free-run CLK/2 on ch1, stop in the HIGH half of the 6th period.
        cfg(3'd1, 8'd0, 1'b0, 16'd0, 8'd0);
        pulse_start(2'b10);
        rises = 0; seen = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            check("fr_clk", 8'(clk_o[1]), 8'(k % 2));
            if (rise_o[1]) rises++;
            seen = seen | done[1];
            if (k == 11) stop = 2'b10;
            tick();
            stop = '0;
        end
        check("fr_lowclk",  8'(clk_o[1]), 8'h0);
        check("fr_lowbusy", 8'(busy[1]), 8'h1);
        seen = seen | done[1];
        tick();
        check("fr_stopbusy", 8'(busy[1]), 8'h0);
        for (int k = 0; k < 4; k++) begin
            check("fr_norunt", 8'(clk_o[1] | rise_o[1] | busy[1]), 8'h0);
            seen = seen | done[1];
            tick();
        end
        check("fr_rises",  8'(rises), 8'd6);
        check("fr_nodone", 8'(seen), 8'h0);

        // Burst with count=0: immediate done, no activity.
        cfg(3'd0, 8'd9, 1'b1, 16'd0, 8'd0);
        pulse_start(2'b01);
        check("b0_done", 8'(done[0]), 8'h1);
        check("b0_busy", 8'(busy[0]), 8'h0);
        check("b0_clk",  8'(clk_o[0]), 8'h0);
        tick();
        check("b0_after", 8'(done[0] | busy[0] | clk_o[0]), 8'h0);

        // Config write mid-burst must not disturb the running burst.
        cfg(3'd0, 8'd9, 1'b1, 16'd1, 8'd0);
        pulse_start(2'b01);
        tick();
        cfg(3'd0, 8'd4, 1'b1, 16'd1, 8'd0);
        for (int k = 3; k <= 20; k++) begin
            check("cw_oldclk", 8'(clk_o[0]), 8'(k <= 10));
            tick();
        end
        check("cw_olddone", 8'(done[0]), 8'h1);
        tick();
        pulse_start(2'b01);
        for (int k = 1; k <= 10; k++) begin
            check("cw_newclk", 8'(clk_o[0]), 8'(k <= 5));
            check("cw_newbusy", 8'(busy[0]), 8'h1);
            tick();
        end
        check("cw_newdone", 8'(done[0]), 8'h1);
        tick();

        // Reset in the middle of a burst, then start+stop together.
        cfg(3'd0, 8'd4, 1'b1, 16'd2, 8'd0);
        pulse_start(2'b01);
        tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mr_busy", 8'(busy), 8'h0);
        check("mr_clk",  8'(clk_o), 8'h0);
        check("mr_rise", 8'(rise_o), 8'h0);
        check("mr_done", 8'(done), 8'h0);
        start = 2'b01; stop = 2'b01;
        tick();
        start = '0; stop = '0;
        check("ss_busy", 8'(busy[0] | clk_o[0] | done[0]), 8'h0);
        tick();
        check("ss_still", 8'(busy[0] | clk_o[0]), 8'h0);
        // Defaults after reset: free-run, H=10; stop at once, one full period remains.
        pulse_start(2'b01);
        stop = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            check("rd_clk",  8'(clk_o[0]), 8'(k <= 10));
            check("rd_busy", 8'(busy[0]), 8'h1);
            tick();
            stop = '0;
        end
        check("rd_idle",   8'(busy[0]), 8'h0);
        check("rd_nodone", 8'(done[0]), 8'h0);
        tick();

        // Writes to a channel number >= NCH are dropped.
        cfg(3'd1, 8'd2, 1'b1, 16'd1, 8'd0);
        cfg(3'd3, 8'd0, 1'b1, 16'd0, 8'd0);
        pulse_start(2'b10);
        check("oob_done0", 8'(done[1]), 8'h0);
        for (int k = 1; k <= 6; k++) begin
            check("oob_clk",  8'(clk_o[1]), 8'(k <= 3));
            check("oob_busy", 8'(busy[1]), 8'h1);
            tick();
        end
        check("oob_done", 8'(done[1]), 8'h1);
        tick();

        // Phase delay (7 with the option built in, none otherwise), H=10, one pulse.
        cfg(3'd0, 8'd9, 1'b1, 16'd1, 8'd7);
        pulse_start(2'b01);
        for (int k = 1; k <= PH + 20; k++) begin
            check("ph_clk",  8'(clk_o[0]), 8'(k > PH && k <= PH + 10));
            check("ph_rise", 8'(rise_o[0]), 8'(k == PH + 1));
            check("ph_busy", 8'(busy[0]), 8'h1);
            tick();
        end
        check("ph_done", 8'(done[0]), 8'h1);
        check("ph_idle", 8'(busy[0]), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
